// File: rtl/cache_ctrl_if.sv
// MEM-stage / SRAM-controller bundle for cache_ctrl.
// Counter outputs exist only when CACHE_STATS_EN is defined.
interface cache_ctrl_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_R_EN;
  logic        sram_W_EN;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, write_data,
    input  sram_read_data, sram_ready,
    output read_data, ready, sram_R_EN, sram_W_EN,
    output sram_address, sram_write_data
`ifdef CACHE_STATS_EN
    , output hit_count, miss_count
`endif
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, write_data,
    output sram_read_data, sram_ready,
    input  read_data, ready, sram_R_EN, sram_W_EN,
    input  sram_address, sram_write_data
`ifdef CACHE_STATS_EN
    , input hit_count, miss_count
`endif
  );
endinterface

// File: rtl/cache_ctrl.sv
// 2-way write-through, no-write-allocate data cache.
// Define CACHE_STATS_EN to add read hit/miss counters.
module cache_ctrl #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.slave bus
);
  localparam int SETS = 2 ** INDEX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RMISS = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]       r_state;
  logic [SETS-1:0]  r_valid0;
  logic [SETS-1:0]  r_valid1;
  logic [SETS-1:0]  r_lru;
  logic [TAG_W-1:0] r_tag0  [SETS];
  logic [TAG_W-1:0] r_tag1  [SETS];
  logic [63:0]      r_data0 [SETS];
  logic [63:0]      r_data1 [SETS];

  logic               w_off;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_rd;
  logic               w_wr;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_victim;
  logic               w_idle;
  logic               w_rhit;
  logic               w_rmiss_go;
  logic               w_wr_go;
  logic               w_fill;
  logic               w_wdone;
  logic [63:0]        w_line;
  logic [63:0]        w_src;
  logic               w_ready;
  logic               w_unused;

  assign w_off = bus.address[2];
  assign w_idx = bus.address[INDEX_W+2:3];
  assign w_tag = bus.address[TAG_W+INDEX_W+2:INDEX_W+3];
  assign w_unused = ^bus.address[1:0];

  // Write has priority when both enables are raised.
  assign w_wr = bus.MEM_W_EN;
  assign w_rd = bus.MEM_R_EN & ~bus.MEM_W_EN;

  assign w_hit0 = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_hit1 = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  assign w_line = w_hit1 ? r_data1[w_idx] : r_data0[w_idx];

  assign w_victim = !r_valid0[w_idx] ? 1'b0 :
                    !r_valid1[w_idx] ? 1'b1 : r_lru[w_idx];

  assign w_idle     = (r_state == S_IDLE);
  assign w_rhit     = w_idle & w_rd & w_hit;
  assign w_rmiss_go = w_idle & w_rd & ~w_hit;
  assign w_wr_go    = w_idle & w_wr;
  assign w_fill     = (r_state == S_RMISS) & bus.sram_ready;
  assign w_wdone    = (r_state == S_WRITE) & bus.sram_ready;

  always_comb begin
    w_ready = 1'b1;
    unique case (r_state)
      S_RMISS: w_ready = bus.sram_ready;
      S_WRITE: w_ready = bus.sram_ready;
      default: w_ready = ~(w_wr | (w_rd & ~w_hit));
    endcase
  end

  assign w_src = (r_state == S_RMISS) ? bus.sram_read_data : w_line;

  assign bus.ready           = w_ready;
  assign bus.read_data       = w_off ? w_src[31:0] : w_src[63:32];
  assign bus.sram_address    = {2'b00, bus.address[31:2]};
  assign bus.sram_write_data = bus.write_data;
  // Enables are gated by rst so they fall the moment reset is applied.
  assign bus.sram_R_EN = rst & ((r_state == S_RMISS) | w_rmiss_go);
  assign bus.sram_W_EN = rst & ((r_state == S_WRITE) | w_wr_go);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_wr_go)         r_state <= S_WRITE;
          else if (w_rmiss_go) r_state <= S_RMISS;
        end
        S_RMISS: if (bus.sram_ready) r_state <= S_IDLE;
        S_WRITE: if (bus.sram_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_rhit || (w_wdone && w_hit))
        r_lru[w_idx] <= ~w_hit1;
      if (w_fill) begin
        if (w_victim) r_valid1[w_idx] <= 1'b1;
        else          r_valid0[w_idx] <= 1'b1;
        r_lru[w_idx] <= ~w_victim;
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (w_victim) begin
        r_tag1[w_idx]  <= w_tag;
        r_data1[w_idx] <= bus.sram_read_data;
      end else begin
        r_tag0[w_idx]  <= w_tag;
        r_data0[w_idx] <= bus.sram_read_data;
      end
    end
    if (w_wdone && w_hit1) begin
      if (w_off) r_data1[w_idx][31:0]  <= bus.write_data;
      else       r_data1[w_idx][63:32] <= bus.write_data;
    end
    if (w_wdone && w_hit0) begin
      if (w_off) r_data0[w_idx][31:0]  <= bus.write_data;
      else       r_data0[w_idx][63:32] <= bus.write_data;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_rhit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_fill) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: misses, hits, LRU eviction,
// write-through, write/read priority and reset mid-miss.
module tb_cache_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [63:0] line);
    step();
    bus.address = a;
    bus.MEM_R_EN = 1'b1;
    step();
    bus.sram_read_data = line;
    bus.sram_ready = 1'b1;
    step();
    bus.MEM_R_EN = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step();
    bus.address = a;
    bus.write_data = d;
    bus.MEM_W_EN = 1'b1;
    step();
    bus.sram_ready = 1'b1;
    step();
    bus.MEM_W_EN = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready: got %b exp 1", bus.ready);
    end
    n_checks++;
    if (bus.sram_R_EN !== 1'b0) begin
      n_fail++; $display("FAIL rst_sram_R_EN: got %b exp 0", bus.sram_R_EN);
    end
    n_checks++;
    if (bus.sram_W_EN !== 1'b0) begin
      n_fail++; $display("FAIL rst_sram_W_EN: got %b exp 0", bus.sram_W_EN);
    end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_counts: got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count);
    end
`endif
    step();
    rst = 1'b1;
  endtask

  task automatic test_read_miss();
    step();
    bus.address = 32'h400;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.sram_R_EN !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_req: got R_EN=%b ready=%b exp 1/0", bus.sram_R_EN, bus.ready);
    end
    n_checks++;
    if (bus.sram_address !== 32'h100) begin
      n_fail++; $display("FAIL miss_addr: got %h exp 00000100", bus.sram_address);
    end
    step();
    n_checks++;
    if (bus.sram_R_EN !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_wait: got R_EN=%b ready=%b exp 1/0", bus.sram_R_EN, bus.ready);
    end
    bus.sram_read_data = 64'hAAAA_AAAA_5555_5555;
    bus.sram_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL miss_data: got ready=%b data=%h exp 1/aaaaaaaa", bus.ready, bus.read_data);
    end
    step();
    bus.MEM_R_EN = 1'b0;
    bus.sram_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.sram_R_EN !== 1'b0 || bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_idle: got R_EN=%b ready=%b exp 0/1", bus.sram_R_EN, bus.ready);
    end
  endtask

  task automatic test_read_hit();
    step();
    bus.address = 32'h404;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL hit_data: got ready=%b data=%h exp 1/55555555", bus.ready, bus.read_data);
    end
    n_checks++;
    if (bus.sram_R_EN !== 1'b0) begin
      n_fail++; $display("FAIL hit_no_sram: got %b exp 0", bus.sram_R_EN);
    end
    step();
    bus.MEM_R_EN = 1'b0;
`ifdef CACHE_STATS_EN
    #1;
    n_checks++;
    if (bus.hit_count !== 32'd1 || bus.miss_count !== 32'd1) begin
      n_fail++;
      $display("FAIL hit_counts: got %0d/%0d exp 1/1", bus.hit_count, bus.miss_count);
    end
`endif
  endtask

  task automatic test_lru();
    step();
    bus.address = 32'h400;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL lru_a_hit: got ready=%b data=%h exp 1/aaaaaaaa", bus.ready, bus.read_data);
    end
    step();
    bus.MEM_R_EN = 1'b0;
    fill(32'h600, 64'hBBBB_BBBB_1111_1111);
    fill(32'h800, 64'hCCCC_CCCC_2222_2222);
    step();
    bus.address = 32'h600;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hBBBB_BBBB || bus.sram_R_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL lru_b_hit: got ready=%b data=%h R_EN=%b exp 1/bbbbbbbb/0",
               bus.ready, bus.read_data, bus.sram_R_EN);
    end
    step();
    bus.MEM_R_EN = 1'b0;
    step();
    bus.address = 32'h400;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.sram_R_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL lru_a_evicted: got ready=%b R_EN=%b exp 0/1", bus.ready, bus.sram_R_EN);
    end
    step();
    bus.sram_read_data = 64'hAAAA_AAAA_5555_5555;
    bus.sram_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.read_data !== 32'hAAAA_AAAA) begin
      n_fail++; $display("FAIL lru_a_refill: got %h exp aaaaaaaa", bus.read_data);
    end
    step();
    bus.MEM_R_EN = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  task automatic test_write_hit();
    step();
    bus.address = 32'h404;
    bus.write_data = 32'h1234_5678;
    bus.MEM_W_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.sram_W_EN !== 1'b1 || bus.ready !== 1'b0 || bus.sram_R_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_req: got W_EN=%b ready=%b R_EN=%b exp 1/0/0",
               bus.sram_W_EN, bus.ready, bus.sram_R_EN);
    end
    n_checks++;
    if (bus.sram_write_data !== 32'h1234_5678 || bus.sram_address !== 32'h101) begin
      n_fail++;
      $display("FAIL wr_bus: got data=%h addr=%h exp 12345678/00000101",
               bus.sram_write_data, bus.sram_address);
    end
    step();
    n_checks++;
    if (bus.sram_W_EN !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_wait: got W_EN=%b ready=%b exp 1/0", bus.sram_W_EN, bus.ready);
    end
    bus.sram_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_done: got %b exp 1", bus.ready);
    end
    step();
    bus.MEM_W_EN = 1'b0;
    bus.sram_ready = 1'b0;
    step();
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'h1234_5678 || bus.sram_R_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_readback: got ready=%b data=%h R_EN=%b exp 1/12345678/0",
               bus.ready, bus.read_data, bus.sram_R_EN);
    end
    step();
    bus.address = 32'h400;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL wr_other_word: got ready=%b data=%h exp 1/aaaaaaaa", bus.ready, bus.read_data);
    end
    step();
    bus.MEM_R_EN = 1'b0;
  endtask

  task automatic test_write_miss();
    wr(32'hC00, 32'hDEAD_BEEF);
    step();
    bus.address = 32'hC00;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.sram_R_EN !== 1'b1 || bus.sram_address !== 32'h300) begin
      n_fail++;
      $display("FAIL wmiss_no_alloc: got ready=%b R_EN=%b addr=%h exp 0/1/00000300",
               bus.ready, bus.sram_R_EN, bus.sram_address);
    end
    step();
    bus.sram_read_data = 64'hDDDD_DDDD_4444_4444;
    bus.sram_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.read_data !== 32'hDDDD_DDDD) begin
      n_fail++; $display("FAIL wmiss_fill: got %h exp dddddddd", bus.read_data);
    end
    step();
    bus.MEM_R_EN = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  task automatic test_both_enables();
    step();
    bus.address = 32'h400;
    bus.write_data = 32'h0BAD_F00D;
    bus.MEM_R_EN = 1'b1;
    bus.MEM_W_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.sram_W_EN !== 1'b1 || bus.sram_R_EN !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL both_write_wins: got W_EN=%b R_EN=%b ready=%b exp 1/0/0",
               bus.sram_W_EN, bus.sram_R_EN, bus.ready);
    end
    step();
    bus.sram_ready = 1'b1;
    step();
    bus.MEM_W_EN = 1'b0;
    bus.sram_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.read_data !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL both_readback: got ready=%b data=%h exp 1/0badf00d", bus.ready, bus.read_data);
    end
    step();
    bus.MEM_R_EN = 1'b0;
  endtask

  task automatic test_idle_sram_ready();
    step();
    bus.sram_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.sram_R_EN !== 1'b0 || bus.sram_W_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_pulse: got ready=%b R_EN=%b W_EN=%b exp 1/0/0",
               bus.ready, bus.sram_R_EN, bus.sram_W_EN);
    end
    step();
    bus.sram_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_stay: got ready=%b exp 1", bus.ready);
    end
  endtask

  task automatic test_reset_mid_miss();
    step();
    bus.address = 32'h408;
    bus.MEM_R_EN = 1'b1;
    step();
    n_checks++;
    if (bus.sram_R_EN !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pending: got %b exp 1", bus.sram_R_EN);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.sram_R_EN !== 1'b0) begin
      n_fail++; $display("FAIL rmid_drop: got %b exp 0", bus.sram_R_EN);
    end
`ifdef CACHE_STATS_EN
    n_checks++;
    if (bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rmid_counts: got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count);
    end
`endif
    step();
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.sram_R_EN !== 1'b1 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_remiss: got R_EN=%b ready=%b exp 1/0", bus.sram_R_EN, bus.ready);
    end
    step();
    bus.sram_read_data = 64'h0123_4567_89AB_CDEF;
    bus.sram_ready = 1'b1;
    step();
    bus.MEM_R_EN = 1'b0;
    bus.sram_ready = 1'b0;
    step();
    bus.address = 32'h400;
    bus.MEM_R_EN = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b0 || bus.sram_R_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_invalidated: got ready=%b R_EN=%b exp 0/1", bus.ready, bus.sram_R_EN);
    end
    step();
    bus.sram_read_data = 64'hAAAA_AAAA_5555_5555;
    bus.sram_ready = 1'b1;
    step();
    bus.MEM_R_EN = 1'b0;
    bus.sram_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.address = 32'h0;
    bus.write_data = 32'h0;
    bus.sram_read_data = 64'h0;
    bus.sram_ready = 1'b0;
    step();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_lru();
    test_write_hit();
    test_write_miss();
    test_both_enables();
    test_idle_sram_ready();
    test_reset_mid_miss();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
